periodic_enable_scheduler: RTL and testbench

Parametrised HLC scheduler for the RTLola monitor. It divides the fast LLC clock into STAGES-cycle HLC cycles and drives NUM_CH drift-free periodic-stream enables. It also captures asynchronous input events and presents them as a single-cycle enable aligned to HLC stage 0. It supersedes the fixed single-timer, 4-stage enable logic, and sits between the input interface and the generated stream-evaluation pipeline.

---
 rtl/periodic_enable_scheduler.sv | 162 ++++++++++++++++
 tb/tb_periodic_enable_scheduler.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/periodic_enable_scheduler.sv
// periodic_enable_scheduler
//   Splits the LLC clock into STAGES-cycle HLC cycles. Produces one periodic
//   enable per channel, with no drift, and turns asynchronous input events into a
//   single-cycle enable that is aligned to HLC stage 0.
// Ports
//   clk, rst        LLC clock, asynchronous active-low reset
//   en              run enable (stage/timers/count hold while low)
//   new_input       event strobe, input_a is its payload
//   stage           LLC stage within the current HLC cycle
//   hlc_clock       derived HLC clock (registered)
//   hlc_clock_cnt   number of completed HLC cycles
//   evt_en/evt_data event enable pulse and the captured payload
//   per_en          per-channel periodic enable pulses
//   timer_cur       per-channel accumulated time, packed NUM_CH x TW
//   evt_overrun     sticky flag: an event was overwritten inside one window

// One periodic channel. Each boundary adds STAGES LLC cycles to the timer.
// The residual that remains after a fire is kept, so the period does not drift.
module periodic_channel #(
  parameter int unsigned       STAGES = 4,
  parameter int unsigned       TW     = 32,
  parameter logic [TW-1:0]     PERIOD = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          boundary,
  output logic          fire,
  output logic [TW-1:0] timer
);
  localparam logic [TW:0] PERIOD_EXT = {1'b0, PERIOD};

  // Carry bit so that timer + STAGES never wraps near the top of the range.
  logic [TW:0] sum;
  assign sum = {1'b0, timer} + (TW+1)'(STAGES);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer <= '0;
      fire  <= 1'b0;
    end else begin
      fire <= 1'b0;
      if (boundary) begin
        if (sum >= PERIOD_EXT) begin
          timer <= TW'(sum - PERIOD_EXT);
          fire  <= 1'b1;
        end else begin
          timer <= sum[TW-1:0];
        end
      end
    end
  end
endmodule

module periodic_enable_scheduler #(
  parameter int unsigned             STAGES  = 4,
  parameter int unsigned             NUM_CH  = 2,
  parameter int unsigned             TW      = 32,
  parameter int unsigned             IN_W    = 64,
  parameter logic [NUM_CH*TW-1:0]    PERIODS = {32'd12, 32'd10},
  localparam int unsigned            SW      = $clog2(STAGES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   new_input,
  input  logic [IN_W-1:0]        input_a,
  output logic [SW-1:0]          stage,
  output logic                   hlc_clock,
  output logic [63:0]            hlc_clock_cnt,
  output logic                   evt_en,
  output logic [IN_W-1:0]        evt_data,
  output logic [NUM_CH-1:0]      per_en,
  output logic [NUM_CH*TW-1:0]   timer_cur,
  output logic                   evt_overrun
);

  // Parameter sanity checks at elaboration time
  if ((STAGES < 2) || ((STAGES & (STAGES - 1)) != 0)) begin : g_bad_stages
    $error("STAGES must be a power of two and at least 2");
  end

  // Stage counter / boundary
  logic [SW-1:0] stage_nxt;
  logic          boundary;
  logic          started;

  assign boundary  = en && (stage == SW'(STAGES - 1));
  // STAGES is a power of two, so the natural wrap of the adder is the stage wrap.
  assign stage_nxt = en ? stage + SW'(1) : stage;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage         <= '0;
      started       <= 1'b0;
      hlc_clock     <= 1'b0;
      hlc_clock_cnt <= '0;
    end else begin
      stage <= stage_nxt;
      if (boundary) begin
        started       <= 1'b1;
        hlc_clock_cnt <= hlc_clock_cnt + 64'd1;
      end
      // The register is computed from the next stage, which keeps hlc_clock aligned
      // with the stage value it reflects. It stays low until the first HLC cycle
      // has completed.
      hlc_clock <= (started || boundary) && (stage_nxt < SW'(STAGES / 2));
    end
  end

  // Periodic channels
  logic [NUM_CH-1:0][TW-1:0] timer_arr;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    if (PERIODS[i*TW +: TW] < TW'(STAGES)) begin : g_bad_period
      $error("each period must be at least STAGES");
    end
    periodic_channel #(
      .STAGES (STAGES),
      .TW     (TW),
      .PERIOD (PERIODS[i*TW +: TW])
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .boundary (boundary),
      .fire     (per_en[i]),
      .timer    (timer_arr[i])
    );
  end

  assign timer_cur = timer_arr;

  // Event capture and release
  logic            pending;
  logic [IN_W-1:0] latch;
  logic            release_evt;

  // A strobe that arrives in the boundary cycle belongs to the window being closed.
  assign release_evt = boundary && (pending || new_input);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending     <= 1'b0;
      latch       <= '0;
      evt_en      <= 1'b0;
      evt_data    <= '0;
      evt_overrun <= 1'b0;
    end else begin
      evt_en <= release_evt;
      if (new_input) begin
        latch <= input_a;
        if (pending) evt_overrun <= 1'b1;
      end
      if (release_evt) begin
        evt_data <= new_input ? input_a : latch;
        pending  <= 1'b0;
      end else if (new_input) begin
        pending  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_periodic_enable_scheduler.sv
// Randomized scoreboard bench for periodic_enable_scheduler. The reference model
// counts enabled LLC cycles and derives stage, HLC count, timers and fire
// instants from them using plain arithmetic.
module tb_periodic_enable_scheduler;
  localparam int unsigned S      = 4;
  localparam int unsigned NUM_CH = 2;
  localparam int unsigned TW     = 32;
  localparam int unsigned IN_W   = 64;
  localparam logic [NUM_CH*TW-1:0] PER = {32'd12, 32'd10};
  localparam int unsigned SW     = $clog2(S);

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 en = 1'b0;
  logic                 new_input = 1'b0;
  logic [IN_W-1:0]      input_a = '0;
  logic [SW-1:0]        stage;
  logic                 hlc_clock;
  logic [63:0]          hlc_clock_cnt;
  logic                 evt_en;
  logic [IN_W-1:0]      evt_data;
  logic [NUM_CH-1:0]    per_en;
  logic [NUM_CH*TW-1:0] timer_cur;
  logic                 evt_overrun;

  periodic_enable_scheduler #(
    .STAGES(S), .NUM_CH(NUM_CH), .TW(TW), .IN_W(IN_W), .PERIODS(PER)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .new_input(new_input), .input_a(input_a),
    .stage(stage), .hlc_clock(hlc_clock), .hlc_clock_cnt(hlc_clock_cnt),
    .evt_en(evt_en), .evt_data(evt_data), .per_en(per_en),
    .timer_cur(timer_cur), .evt_overrun(evt_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_CH-1:0] per;
    logic              evt;
  } exp_t;
  exp_t q[$];

  // Reference model state
  longint unsigned n;          // enabled LLC cycles since reset
  bit              pend, ovr;
  logic [IN_W-1:0] pdata, last_data;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint unsigned period(input int c);
    logic [NUM_CH*TW-1:0] p;
    p = PER;
    return longint'(p[c*TW +: TW]);
  endfunction

  task automatic model_reset();
    n = 0; pend = 0; ovr = 0; pdata = '0; last_data = '0;
    q.delete();
  endtask

  task automatic model_step(input bit e, input bit ni, input logic [IN_W-1:0] a);
    bit bnd;
    longint unsigned b;
    exp_t x;
    bnd = e && (n % S == S - 1);
    x.per = '0; x.evt = 1'b0;
    if (ni) begin
      if (pend) ovr = 1;
      pdata = a;
      pend  = 1;
    end
    if (bnd && pend) begin
      x.evt = 1'b1; last_data = pdata; pend = 0;
    end
    if (e) n++;
    if (bnd) begin
      b = n / S;
      for (int c = 0; c < NUM_CH; c++)
        if ((b * S) / period(c) != ((b - 1) * S) / period(c)) x.per[c] = 1'b1;
    end
    if (x.evt || x.per != '0) q.push_back(x);
  endtask

  // Applies the inputs, runs one clock and leaves time at posedge+1
  task automatic step(input bit e, input bit ni, input logic [IN_W-1:0] a);
    en = e; new_input = ni; input_a = a;
    @(posedge clk);
    if (rst) model_step(e, ni, a);
    #1;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b1, 1'b0, '0);
  endtask

  task automatic to_stage(input int s);
    while (n % S != s) step(1'b1, 1'b0, '0);
  endtask

  task automatic do_reset();
    #1;
    rst = 1'b0;
    model_reset();
    en = 1'b0; new_input = 1'b0; input_a = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Monitor: compares observable state each cycle and consumes the scoreboard
  // whenever a pulse is present or expected.
  always @(negedge clk) begin
    longint unsigned b;
    exp_t x;
    b = n / S;
    chk("stage", 64'(stage), n % S);
    chk("hlc_clock", 64'(hlc_clock), 64'((n >= S) && (n % S < S / 2)));
    chk("hlc_clock_cnt", hlc_clock_cnt, b);
    for (int c = 0; c < NUM_CH; c++)
      chk($sformatf("timer_cur[%0d]", c), 64'(timer_cur[c*TW +: TW]), (b * S) % period(c));
    chk("evt_overrun", 64'(evt_overrun), 64'(ovr));
    chk("evt_data", evt_data, last_data);
    if (per_en != '0 || evt_en || q.size() > 0) begin
      if (q.size() == 0) begin
        chk("unexpected per_en", 64'(per_en), 64'd0);
        chk("unexpected evt_en", 64'(evt_en), 64'd0);
      end else begin
        x = q.pop_front();
        chk("per_en", 64'(per_en), 64'(x.per));
        chk("evt_en", 64'(evt_en), 64'(x.evt));
      end
    end
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Free run: hlc_clock pattern, counts, drift-free channel fires
    idle(44);
    // Event strobed at stage 0, then one strobed in the boundary cycle
    to_stage(0); step(1'b1, 1'b1, 64'd1); idle(6);
    to_stage(3); step(1'b1, 1'b1, 64'd5); idle(4);
    // Two strobes in one window
    to_stage(0); step(1'b1, 1'b1, 64'd2); step(1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 64'd3); idle(6);
    // en low for 10 clocks with an event captured during the pause
    to_stage(2);
    repeat (3) step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 64'h77);
    repeat (6) step(1'b0, 1'b0, '0);
    idle(8);
    // Reset mid-window while an event is pending and timers are nonzero
    to_stage(1); step(1'b1, 1'b1, 64'd9); step(1'b1, 1'b0, '0);
    do_reset(); idle(12);
    // Reset during a pulse cycle: the pulse in flight is dropped
    idle(8); to_stage(3); step(1'b1, 1'b1, 64'd4);
    do_reset(); idle(20);

    // Random phase
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(999) < 2) do_reset();
      else step($urandom_range(99) < 85, $urandom_range(99) < 20,
                {$urandom, $urandom});
    end
    idle(8);
    @(negedge clk);
    #1 chk("scoreboard drained", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
